bft_leaf_adapter: RTL

BFT_LEAF_ADAPTER -- requirements
Module: bft_leaf_adapter

---
 rtl/bft_leaf_adapter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bft_leaf_adapter.sv
// Leaf adapter between a BFT packet port and NUM_IN outbound / NUM_OUT inbound streams.
// Outbound beats are round-robin arbitrated into one 49-bit packet register; inbound packets fill per-port FIFOs.
module bft_leaf_adapter #(
    parameter int       NUM_IN     = 2,
    parameter int       NUM_OUT    = 2,
    parameter int       PAYLOAD_W  = 32,
    parameter int       FIFO_DEPTH = 16,
    parameter logic [2:0] LEAF_ID  = 3'd1
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic [48:0]                    din_leaf_bft2interface,
    output logic [48:0]                    dout_leaf_interface2bft,
    input  logic                           resend,
    input  logic [NUM_IN*PAYLOAD_W-1:0]    in_tdata,
    input  logic [NUM_IN-1:0]              in_tvalid,
    output logic [NUM_IN-1:0]              in_tready,
    output logic [NUM_OUT*PAYLOAD_W-1:0]   out_tdata,
    output logic [NUM_OUT-1:0]             out_tvalid,
    input  logic [NUM_OUT-1:0]             out_tready,
    output logic [NUM_OUT-1:0]             ovf_flag
);

    localparam int PW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(FIFO_DEPTH);

    function automatic logic [31:0] zext_payload(input logic [PAYLOAD_W-1:0] d);
        logic [31:0] r;
        r = 32'd0;
        r[PAYLOAD_W-1:0] = d;
        return r;
    endfunction

    // Inbound packet decode
    logic        din_hit_s;
    logic        cfg_s;
    logic [2:0]  din_leaf_s;
    logic [3:0]  din_port_s;
    logic [31:0] din_payload_s;
    logic [3:0]  cfg_ch_s;
    logic        unused_din_s;

    assign din_leaf_s    = din_leaf_bft2interface[47:45];
    assign din_port_s    = din_leaf_bft2interface[44:41];
    assign din_payload_s = din_leaf_bft2interface[31:0];
    assign din_hit_s     = din_leaf_bft2interface[48] && (din_leaf_s == LEAF_ID);
    assign cfg_s         = din_hit_s && (din_port_s == 4'd0);
    assign cfg_ch_s      = din_payload_s[19:16];
    assign unused_din_s  = ^din_leaf_bft2interface[40:32];

    logic [NUM_IN-1:0] route_en_q;
    logic [2:0]        route_leaf_q [NUM_IN];
    logic [3:0]        route_port_q [NUM_IN];

    // Route registers, written by port-0 config packets
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            route_en_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                route_leaf_q[i] <= 3'd0;
                route_port_q[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (cfg_s && (cfg_ch_s == 4'(i))) begin
                    route_en_q[i]   <= din_payload_s[31];
                    route_leaf_q[i] <= din_payload_s[6:4];
                    route_port_q[i] <= din_payload_s[3:0];
                end
            end
        end
    end

    logic [48:0]       dout_q, dout_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_IN-1:0] req_s;
    logic              free_s;
    logic              grant_found_s;
    logic [PW-1:0]     grant_idx_s;
    logic [PW-1:0]     cand_s;

    assign free_s = !dout_q[48] || !resend;

    // Round-robin search starting at rr_ptr_q
    always_comb begin
        req_s         = route_en_q & in_tvalid;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int off = 0; off < NUM_IN; off++) begin
            cand_s = PW'((int'(rr_ptr_q) + off) % NUM_IN);
            if (!grant_found_s && req_s[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Ready, next packet and next arbiter pointer
    always_comb begin
        in_tready = '0;
        dout_d    = dout_q;
        rr_ptr_d  = rr_ptr_q;
        if (free_s) begin
            if (grant_found_s) begin
                in_tready[grant_idx_s] = 1'b1;
                dout_d   = {1'b1, route_leaf_q[grant_idx_s], route_port_q[grant_idx_s], 9'd0,
                            zext_payload(in_tdata[int'(grant_idx_s)*PAYLOAD_W +: PAYLOAD_W])};
                rr_ptr_d = PW'((int'(grant_idx_s) + 1) % NUM_IN);
            end else begin
                dout_d = 49'd0;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // Outbound packet register and arbiter pointer
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dout_q   <= 49'd0;
            rr_ptr_q <= '0;
        end else begin
            dout_q   <= dout_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign dout_leaf_interface2bft = dout_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_fifo
        logic [PAYLOAD_W-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
        logic                 ovf_q, ovf_d;
        logic                 full_s, empty_s, wr_hit_s, wr_s, rd_s;

        assign full_s   = (wptr_q - rptr_q) == PTR_DEPTH;
        assign empty_s  = (wptr_q == rptr_q);
        assign wr_hit_s = din_hit_s && (din_port_s == 4'(g + 1));
        assign wr_s     = wr_hit_s && !full_s;
        assign rd_s     = !empty_s && out_tready[g];

        // Fullness is taken from the start of cycle, so a same-cycle read never rescues a write
        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            ovf_d  = ovf_q | (wr_hit_s & full_s);
            if (wr_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
        end

        // Pointer and sticky overflow state
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                wptr_q <= '0;
                rptr_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                ovf_q  <= ovf_d;
            end
        end

        // Storage; contents are meaningless once the pointers are reset
        always_ff @(posedge ap_clk) begin
            if (wr_s) begin
                mem_q[wptr_q[AW-1:0]] <= din_payload_s[PAYLOAD_W-1:0];
            end
        end

        assign out_tvalid[g]                         = !empty_s;
        assign out_tdata[g*PAYLOAD_W +: PAYLOAD_W]   = mem_q[rptr_q[AW-1:0]];
        assign ovf_flag[g]                           = ovf_q;
    end

endmodule
